// File: rtl/pp_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pp_rr_arbiter
// Description : Round-robin arbiter merging N rdy/ack producer streams onto a
//               single registered rdy/ack output, with an optional burst
//               limit that lets a winner keep the grant for several transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module pp_rr_arbiter #(
    parameter int N         = 4,
    parameter int BW        = 32,
    parameter int MAX_BURST = 1,
    localparam int IW       = (N > 1) ? $clog2(N) : 1,
    localparam int BCW      = $clog2(MAX_BURST + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    i_rdy,
    input  logic [N*BW-1:0] i_dat,
    output logic [N-1:0]    i_ack,
    output logic            o_rdy,
    output logic [BW-1:0]   o_dat,
    output logic [IW-1:0]   o_id,
    input  logic            o_ack
);

    // Pointer starts on the last requester with an exhausted burst so the
    // very first grant rotates and requester 0 gets first priority.
    localparam logic [IW-1:0]  C_PTR_RST  = IW'(N - 1);
    localparam logic [BCW-1:0] C_BCNT_RST = BCW'(MAX_BURST);
    localparam logic [IW-1:0]  C_IDX_LAST = IW'(N - 1);

    logic            o_rdy_q, o_rdy_d;
    logic [BW-1:0]   o_dat_q, o_dat_d;
    logic [IW-1:0]   o_id_q,  o_id_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [BCW-1:0]  bcnt_q,  bcnt_d;

    logic            w_free;
    logic            w_load;
    logic            w_sticky;
    logic            w_found;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_rot_idx;
    logic [IW-1:0]   w_win;
    logic [BW-1:0]   w_win_dat;

    // Winner selection: sticky burst continuation first, else rotating scan.
    always_comb begin
        w_free    = !o_rdy_q || o_ack;
        // Gating with rst_n keeps i_ack low for the whole reset assertion.
        w_load    = rst_n && w_free && (|i_rdy);
        w_sticky  = i_rdy[ptr_q] && (bcnt_q < C_BCNT_RST);

        // Scan ptr+1, ptr+2, ... wrapping at N; ptr itself is visited last.
        w_found   = 1'b0;
        w_rot_idx = ptr_q;
        w_idx     = ptr_q;
        for (int off = 0; off < N; off++) begin
            w_idx = (w_idx == C_IDX_LAST) ? '0 : w_idx + 1'b1;
            if (!w_found && i_rdy[w_idx]) begin
                w_found   = 1'b1;
                w_rot_idx = w_idx;
            end
        end

        w_win = w_sticky ? ptr_q : w_rot_idx;
        i_ack = w_load ? (N'(1) << w_win) : '0;

        // AND-OR mux keyed on the grant so only the winner's data is looked
        // at; unknowns on idle inputs never reach the output register.
        w_win_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (i_ack[k]) begin
                w_win_dat = i_dat[k*BW +: BW];
            end
        end
    end

    // Next-state: load on a grant, drain when free and idle, hold on stall.
    always_comb begin
        o_rdy_d = o_rdy_q;
        o_dat_d = o_dat_q;
        o_id_d  = o_id_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        if (w_load) begin
            o_rdy_d = 1'b1;
            o_dat_d = w_win_dat;
            o_id_d  = w_win;
            if (w_sticky) begin
                bcnt_d = bcnt_q + 1'b1;
            end else begin
                ptr_d  = w_rot_idx;
                bcnt_d = BCW'(1);
            end
        end else if (w_free) begin
            o_rdy_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdy_q <= 1'b0;
            o_dat_q <= '0;
            o_id_q  <= '0;
            ptr_q   <= C_PTR_RST;
            bcnt_q  <= C_BCNT_RST;
        end else begin
            o_rdy_q <= o_rdy_d;
            o_dat_q <= o_dat_d;
            o_id_q  <= o_id_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign o_rdy = o_rdy_q;
    assign o_dat = o_dat_q;
    assign o_id  = o_id_q;

endmodule
`default_nettype wire

// File: tb/tb_pp_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pp_rr_arbiter
// Description : Self-checking bench for pp_rr_arbiter. Two instances share
//               one stimulus: u_rr (MAX_BURST=1) and u_bst (MAX_BURST=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   rdy = '0;
    logic [127:0] dat = '0;
    logic         oack = 1'b0;
    logic         sel = 1'b0;

    logic [3:0]   ack_a, ack_b;
    logic         ordy_a, ordy_b;
    logic [31:0]  odat_a, odat_b;
    logic [1:0]   oid_a, oid_b;

    logic [3:0]   w_ack;
    logic         w_ordy;
    logic [31:0]  w_odat;
    logic [1:0]   w_oid;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       sel;
        logic [3:0] rdy;
        logic       oack;
        logic [3:0] exp_ack;
        logic       exp_ordy;
        logic [1:0] exp_id;
    } vec_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] dat;
    } sb_t;

    vec_t vt [32];
    int   n_vec = 0;
    sb_t  sb_q [$];

    pp_rr_arbiter #(.N(4), .BW(32), .MAX_BURST(1)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_rdy (rdy),
        .i_dat (dat),
        .i_ack (ack_a),
        .o_rdy (ordy_a),
        .o_dat (odat_a),
        .o_id  (oid_a),
        .o_ack (oack)
    );

    pp_rr_arbiter #(.N(4), .BW(32), .MAX_BURST(3)) u_bst (
        .clk   (clk),
        .rst_n (rst_n),
        .i_rdy (rdy),
        .i_dat (dat),
        .i_ack (ack_b),
        .o_rdy (ordy_b),
        .o_dat (odat_b),
        .o_id  (oid_b),
        .o_ack (oack)
    );

    assign w_ack  = sel ? ack_b  : ack_a;
    assign w_ordy = sel ? ordy_b : ordy_a;
    assign w_odat = sel ? odat_b : odat_a;
    assign w_oid  = sel ? oid_b  : oid_a;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pop the item leaving the output register, then push the item granted now.
    task automatic sb_step(input logic [3:0] acks);
        sb_t e;
        int  idx;
        if (w_ordy && oack) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: actual=output id %0d expected=no output", w_oid);
            end else begin
                e = sb_q.pop_front();
                chk("sb_id", 32'(w_oid), 32'(e.id));
                chk("sb_dat", w_odat, e.dat);
            end
        end
        if (acks != 4'b0000) begin
            idx = 0;
            for (int k = 3; k >= 0; k--) if (acks[k]) idx = k;
            e.id  = 2'(idx);
            e.dat = dat[idx*32 +: 32];
            sb_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rdy   = '0;
        oack  = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic [3:0] r, input logic oa,
                       input logic [3:0] ea, input logic eo, input logic [1:0] ei);
        vt[n_vec] = '{s, r, oa, ea, eo, ei};
        n_vec++;
    endtask

    initial begin
        logic [3:0]  acked;
        logic        stalled;
        logic [31:0] prev_dat;
        logic [1:0]  prev_id;
        int          wait_cnt [4];
        int          seq;

        for (int k = 0; k < 4; k++) dat[k*32 +: 32] = 32'(k) * 32'h11;

        // Strict round robin, all requesters ready, downstream always ready.
        add(0, 4'hF, 1, 4'b0001, 0, 2'd0);
        add(0, 4'hF, 1, 4'b0010, 1, 2'd0);
        add(0, 4'hF, 1, 4'b0100, 1, 2'd1);
        add(0, 4'hF, 1, 4'b1000, 1, 2'd2);
        add(0, 4'hF, 1, 4'b0001, 1, 2'd3);
        add(0, 4'hF, 1, 4'b0010, 1, 2'd0);
        add(0, 4'h0, 1, 4'b0000, 1, 2'd1);
        add(0, 4'h0, 1, 4'b0000, 0, 2'd1);
        add(0, 4'h0, 1, 4'b0000, 0, 2'd1);
        // Burst of 3 between requesters 1 and 2.
        add(1, 4'h6, 1, 4'b0010, 0, 2'd0);
        add(1, 4'h6, 1, 4'b0010, 1, 2'd1);
        add(1, 4'h6, 1, 4'b0010, 1, 2'd1);
        add(1, 4'h6, 1, 4'b0100, 1, 2'd1);
        add(1, 4'h6, 1, 4'b0100, 1, 2'd2);
        add(1, 4'h6, 1, 4'b0100, 1, 2'd2);
        add(1, 4'h6, 1, 4'b0010, 1, 2'd2);
        add(1, 4'h6, 1, 4'b0010, 1, 2'd1);
        add(1, 4'h6, 1, 4'b0010, 1, 2'd1);
        add(1, 4'h6, 1, 4'b0100, 1, 2'd1);
        add(1, 4'h6, 1, 4'b0100, 1, 2'd2);
        // Burst owner drops its request mid-burst: rotation is forced.
        add(1, 4'h2, 1, 4'b0010, 1, 2'd2);
        add(1, 4'h0, 1, 4'b0000, 1, 2'd1);

        // Reset / idle on both instances.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #3;
            chk("idle_ctl", {22'd0, ordy_a, ordy_b, ack_a, ack_b}, 32'd0);
            chk("idle_dat", odat_a | odat_b, 32'd0);
            chk("idle_id", {28'd0, oid_a, oid_b}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Table-driven vectors.
        for (int i = 0; i < n_vec; i++) begin
            if (i == 0 || vt[i].sel != vt[i-1].sel) begin
                sel = vt[i].sel;
                do_reset();
            end
            rdy  = vt[i].rdy;
            oack = vt[i].oack;
            #3;
            chk("tbl_ack", 32'(w_ack), 32'(vt[i].exp_ack));
            chk("tbl_ordy", 32'(w_ordy), 32'(vt[i].exp_ordy));
            chk("tbl_id", 32'(w_oid), 32'(vt[i].exp_id));
            sb_step(vt[i].exp_ack);
            @(posedge clk);
            #1;
        end

        // Backpressure: DEADBEEF must hold through 5 stall cycles.
        sel = 1'b0;
        do_reset();
        dat[2*32 +: 32] = 32'hDEADBEEF;
        dat[3*32 +: 32] = 32'h33333333;
        rdy  = 4'b0100;
        oack = 1'b0;
        #3;
        chk("bp_first_ack", 32'(w_ack), 32'b0100);
        sb_step(4'b0100);
        @(posedge clk);
        #1;
        rdy = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            #3;
            chk("bp_stall_ack", 32'(w_ack), 32'd0);
            chk("bp_stall_ordy", 32'(w_ordy), 32'd1);
            chk("bp_stall_dat", w_odat, 32'hDEADBEEF);
            chk("bp_stall_id", 32'(w_oid), 32'd2);
            sb_step(4'b0000);
            @(posedge clk);
            #1;
        end
        oack = 1'b1;
        #3;
        chk("bp_release_ack", 32'(w_ack), 32'b1000);
        sb_step(4'b1000);
        @(posedge clk);
        #1;
        rdy = 4'b0001;
        #3;
        chk("bp_next_ack", 32'(w_ack), 32'b0001);
        chk("bp_next_ordy", 32'(w_ordy), 32'd1);
        sb_step(4'b0001);
        @(posedge clk);
        #1;
        rdy = 4'b0000;
        #3;
        sb_step(4'b0000);
        @(posedge clk);
        #1;

        // Async reset in the middle of a burst (bcnt=2, o_rdy=1).
        sel = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) dat[k*32 +: 32] = 32'(k) * 32'h11;
        rdy  = 4'b0110;
        oack = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_pre_ordy", 32'(w_ordy), 32'd1);
        chk("rst_pre_id", 32'(w_oid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ordy", 32'(w_ordy), 32'd0);
        chk("rst_mid_dat", w_odat, 32'd0);
        chk("rst_mid_ack", 32'(w_ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_post_ack", 32'(w_ack), 32'b0010);
        @(posedge clk);
        #1;
        chk("rst_post_id", 32'(w_oid), 32'd1);
        chk("rst_post_dat", w_odat, 32'h11);

        // Random traffic on the round-robin instance with scoreboard.
        sel = 1'b0;
        do_reset();
        stalled  = 1'b0;
        prev_dat = '0;
        prev_id  = '0;
        seq      = 0;
        for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (!rdy[k] && $urandom_range(255) < 200) begin
                    rdy[k] = 1'b1;
                    dat[k*32 +: 32] = {8'(k), 8'hA5, 16'(seq)};
                    seq++;
                end
            end
            oack = ($urandom_range(3) != 0);
            #3;
            if (stalled) begin
                chk("rand_hold_dat", w_odat, prev_dat);
                chk("rand_hold_id", 32'(w_oid), 32'(prev_id));
            end
            chk("rand_onehot", 32'($onehot0(w_ack)), 32'd1);
            chk("rand_ack_rdy", 32'(w_ack & ~rdy), 32'd0);
            sb_step(w_ack);
            for (int k = 0; k < 4; k++) begin
                if (w_ack[k]) begin
                    wait_cnt[k] = 0;
                end else if (rdy[k] && (|w_ack)) begin
                    wait_cnt[k]++;
                    chk("rand_fair", 32'(wait_cnt[k] > 3), 32'd0);
                end
            end
            stalled  = w_ordy && !oack;
            prev_dat = w_odat;
            prev_id  = w_oid;
            acked    = w_ack;
            @(posedge clk);
            #1;
            rdy = rdy & ~acked;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pp_rr_arbiter.md
# pp_rr_arbiter

Round-robin arbiter that merges N upstream rdy/ack streams onto one downstream rdy/ack stream through a single output register stage. It shares one pipeline consumer (e.g. a multi-cycle datapath core or a file monitor) between several producers. The burst limit lets a winner keep the grant for several consecutive transfers. All ports on both sides follow the team rdy/ack protocol: once rdy is high, rdy and data stay stable until ack.

## Interface
- N, 4: number of requesters, 1..16
- BW, 32: data width per stream
- MAX_BURST, 1: max transfers granted to one requester before rotation is forced; 1 = pure round robin; range 1..255
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_rdy  in  N  per-requester request; bit k belongs to requester k
- i_dat  in  N*BW  requester k data at bits [k*BW +: BW]
- i_ack  out  N  one-hot or zero; bit k = transfer from requester k this cycle
- o_rdy  out  1  output register holds valid data
- o_dat  out  BW  registered data
- o_id  out  IW  index of the requester that supplied o_dat; IW = max(1, $clog2(N))
- o_ack  in  1  downstream accepts o_dat this cycle

## Operation
- State: output register {o_rdy, o_dat, o_id}, grant pointer ptr (IW bits), burst counter bcnt (width $clog2(MAX_BURST+1)).
- Reset values: o_rdy=0, o_dat=0, o_id=0, ptr=N-1, bcnt=MAX_BURST. This forces rotation on the first grant, so requester 0 has first priority.
- free = !o_rdy || o_ack. A load happens when free && |i_rdy.
- Winner selection (combinational, evaluated only when loading):
  - Sticky case: if i_rdy[ptr] && bcnt < MAX_BURST, the winner is ptr and bcnt <= bcnt+1.
  - Otherwise, rotate: the winner is the first k with i_rdy[k], scanning ptr+1, ptr+2, ... mod N, with ptr itself checked last. Then ptr <= k and bcnt <= 1.
- On load: i_ack[winner]=1 in the same cycle. o_dat <= i_dat[winner], o_id <= winner, o_rdy <= 1.
- If free && no i_rdy: o_rdy <= 0. o_dat and o_id hold their old values. ptr and bcnt are unchanged.
- If !free (o_rdy=1 && !o_ack): o_rdy, o_dat and o_id hold; all i_ack=0; ptr and bcnt unchanged.
- i_ack is combinational from i_rdy, o_rdy, o_ack, ptr and bcnt. No path exists from i_dat to i_ack.
- i_dat is sampled only in a load cycle; X on a non-winning or non-ready input must not propagate.
- N=1: the block degenerates to a single register slice; o_id is constant 0.
- MAX_BURST=1: the sticky case never fires, giving strict round robin.

## Timing
- Latency: data accepted (i_ack) at edge t appears on o_dat/o_rdy after edge t; it is visible in cycle t+1.
- Throughput: 1 transfer/cycle when downstream holds o_ack=1 and any i_rdy is high.
- Back-to-back: in a cycle with o_rdy=1 && o_ack=1 && |i_rdy, the register is unloaded and reloaded in the same edge, so o_rdy stays 1.
- Backpressure: o_rdy=1 && o_ack=0 holds o_dat/o_id bit-stable. This must pass the protocol checker for any number of stall cycles.
- Simultaneous requests: exactly one i_ack bit per load cycle.
- A requester whose rdy stays high is acked within (N-1)*MAX_BURST + 1 load cycles.
- Reset mid-operation: an in-flight o_dat is discarded. All state returns to reset values immediately (async). No i_ack is asserted while rst_n=0.
- o_ack while o_rdy=0 is ignored.

## Test plan
- Reset/idle: rst_n low then high, i_rdy=0 -> o_rdy=0, o_dat=0, o_id=0, i_ack=0 for 10 cycles.
- Round robin: N=4, MAX_BURST=1, all i_rdy=1 held, i_dat[k]=k*0x11, o_ack=1 -> o_id sequence 0,1,2,3,0,1,... and o_dat sequence 0x00,0x11,0x22,0x33,... with one transfer per cycle.
- Burst: MAX_BURST=3, requesters 1 and 2 always ready -> o_id sequence 1,1,1,2,2,2,1,1,1.
- Backpressure: o_ack=0 for 5 cycles after o_rdy rises with o_dat=0xDEADBEEF -> o_dat stays 0xDEADBEEF, i_ack=0 throughout; first o_ack=1 cycle reloads the next winner.
- Random traffic: 4 PPRandomSrc/PPFileInitiator inputs (PROB=200) and a PPRandomDst sink with PPCheck on every port. Per-id output streams must match the input files in order, with no protocol abort and 0 monitor errors.
- Async reset mid-burst: assert rst_n low while o_rdy=1, bcnt=2 -> o_rdy=0 immediately. After release, the first grant goes to the lowest-index ready requester.
